// File: rtl/apb_reg_pkg.sv
// apb_reg_pkg
//   Shared types and constants for the APB register slave and its decoder.
//   - apb_slv_state_e : slave FSM states (IDLE, ACCESS)
//   - ADDR_*          : byte offsets of the register map (low 8 address bits)
//   - WAIT_CNT_W      : width of CTRL.wait_cnt and of the wait-state counter
package apb_reg_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_ID       = 8'h04;
  localparam logic [7:0] ADDR_SCRATCH0 = 8'h08;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_reg_decode.sv
// apb_reg_decode
//   Combinational address decoder for the APB register slave.
//   Ports:
//     addr        in   latched byte address
//     write       in   latched direction (1 = write)
//     reg_idx     out  scratch register index (meaningful only with hit_scratch)
//     hit_ctrl    out  address selects CTRL
//     hit_id      out  address selects ID
//     hit_scratch out  address selects a scratch register
//     err         out  access must be answered with pslverr
//                      (no register hit, or a write to the read-only ID)
//   PADDR_WIDTH must be greater than 8: bits above [7:0] are required to be zero.
module apb_reg_decode
  import apb_reg_pkg::*;
#(
  parameter int PADDR_WIDTH = 32,
  parameter int NUM_REGS    = 4
) (
  input  logic [PADDR_WIDTH-1:0] addr,
  input  logic                   write,
  output logic [3:0]             reg_idx,
  output logic                   hit_ctrl,
  output logic                   hit_id,
  output logic                   hit_scratch,
  output logic                   err
);

  // Word index of the first scratch register (address / 4).
  localparam logic [5:0] SCRATCH0_WORD = ADDR_SCRATCH0[7:2];
  localparam logic [5:0] NUM_REGS_W    = 6'(NUM_REGS);

  logic [5:0] word_off_s;
  logic       upper_set_s;
  logic       misalign_s;

  // Classify the latched address into one register hit or an error.
  always_comb begin
    word_off_s  = addr[7:2] - SCRATCH0_WORD;
    upper_set_s = |addr[PADDR_WIDTH-1:8];
    misalign_s  = (addr[1:0] != 2'b00);
    reg_idx     = word_off_s[3:0];
    hit_ctrl    = 1'b0;
    hit_id      = 1'b0;
    hit_scratch = 1'b0;
    if (upper_set_s || misalign_s) begin
      hit_ctrl = 1'b0;
    end else if (addr[7:0] == ADDR_CTRL) begin
      hit_ctrl = 1'b1;
    end else if (addr[7:0] == ADDR_ID) begin
      hit_id = 1'b1;
    end else if ((addr[7:2] >= SCRATCH0_WORD) && (word_off_s < NUM_REGS_W)) begin
      hit_scratch = 1'b1;
    end else begin
      hit_scratch = 1'b0;
    end
    err = !(hit_ctrl || hit_id || hit_scratch) || (hit_id && write);
  end

endmodule

// File: rtl/apb_reg_slave.sv
// apb_reg_slave
//   APB3 slave register bank: CTRL (wait_cnt), read-only ID, NUM_REGS scratch
//   registers. Response latency follows CTRL.wait_cnt captured at setup.
//   Ports:
//     pclock   in   APB clock, rising edge
//     preset   in   synchronous active-high reset
//     paddr    in   byte address, latched in the setup cycle
//     prwd     in   1 = write, 0 = read, latched in the setup cycle
//     pwdata   in   write data, latched in the setup cycle
//     psel     in   slave select
//     penable  in   access phase strobe
//     prdata   out  read data while pready on a read, else 0
//     pready   out  transfer completes this cycle
//     pslverr  out  error response while pready, else 0
//     prot_err out  one-cycle pulse after a protocol violation
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int                PADDR_WIDTH  = 32,
  parameter int                PWDATA_WIDTH = 32,
  parameter int                PRDATA_WIDTH = 32,
  parameter int                NUM_REGS     = 4,
  parameter logic [PRDATA_WIDTH-1:0] ID_VALUE = 32'hA5B0_0001
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic [PADDR_WIDTH-1:0]  paddr,
  input  logic                    prwd,
  input  logic [PWDATA_WIDTH-1:0] pwdata,
  input  logic                    psel,
  input  logic                    penable,
  output logic [PRDATA_WIDTH-1:0] prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic                    prot_err
);

  apb_slv_state_e          state_q, state_d;
  logic [PADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic                    prwd_q, prwd_d;
  logic [PWDATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [WAIT_CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [WAIT_CNT_W-1:0]   ctrl_q, ctrl_d;
  logic [PRDATA_WIDTH-1:0] scratch_q [NUM_REGS];
  logic [PRDATA_WIDTH-1:0] scratch_d [NUM_REGS];
  logic                    prot_err_q, prot_err_d;

  logic [3:0]              dec_idx_s;
  logic                    dec_ctrl_s, dec_id_s, dec_scratch_s, dec_err_s;
  logic [PRDATA_WIDTH-1:0] rdata_s;

  apb_reg_decode #(
    .PADDR_WIDTH (PADDR_WIDTH),
    .NUM_REGS    (NUM_REGS)
  ) u_decode (
    .addr        (paddr_q),
    .write       (prwd_q),
    .reg_idx     (dec_idx_s),
    .hit_ctrl    (dec_ctrl_s),
    .hit_id      (dec_id_s),
    .hit_scratch (dec_scratch_s),
    .err         (dec_err_s)
  );

  // Completion is combinational so that wait_cnt=0 answers in the first access cycle.
  always_comb begin
    pready   = (state_q == ACCESS) && psel && penable && (wcnt_q == '0);
    pslverr  = pready && dec_err_s;
    prot_err = prot_err_q;
    prdata   = (pready && !prwd_q && !dec_err_s) ? rdata_s : '0;
  end

  // Read mux driven from the address latched at setup.
  always_comb begin
    rdata_s = '0;
    if (dec_ctrl_s) begin
      rdata_s = {{(PRDATA_WIDTH-WAIT_CNT_W){1'b0}}, ctrl_q};
    end else if (dec_id_s) begin
      rdata_s = ID_VALUE;
    end else if (dec_scratch_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dec_idx_s == 4'(i)) begin
          rdata_s = scratch_q[i];
        end else begin
          rdata_s = rdata_s;
        end
      end
    end else begin
      rdata_s = '0;
    end
  end

  // FSM next state, request capture, wait counter and register write commit.
  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    prwd_d     = prwd_q;
    pwdata_d   = pwdata_q;
    wcnt_d     = wcnt_q;
    ctrl_d     = ctrl_q;
    scratch_d  = scratch_q;
    prot_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          paddr_d  = paddr;
          prwd_d   = prwd;
          pwdata_d = pwdata;
          wcnt_d   = ctrl_q;
          state_d  = ACCESS;
        end else if (psel && penable) begin
          prot_err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: nothing is committed.
          prot_err_d = 1'b1;
          state_d    = IDLE;
        end else if (!penable) begin
          // A fresh setup arrived mid-transfer: flag it and restart.
          prot_err_d = 1'b1;
          paddr_d    = paddr;
          prwd_d     = prwd;
          pwdata_d   = pwdata;
          wcnt_d     = ctrl_q;
        end else if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          if (prwd_q && !dec_err_s) begin
            if (dec_ctrl_s) begin
              ctrl_d = pwdata_q[WAIT_CNT_W-1:0];
            end else begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (dec_scratch_s && (dec_idx_s == 4'(i))) begin
                  scratch_d[i] = pwdata_q;
                end else begin
                  scratch_d[i] = scratch_q[i];
                end
              end
            end
          end else begin
            ctrl_d = ctrl_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge pclock) begin
    if (preset) begin
      state_q    <= IDLE;
      paddr_q    <= '0;
      prwd_q     <= 1'b0;
      pwdata_q   <= '0;
      wcnt_q     <= '0;
      ctrl_q     <= '0;
      prot_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        scratch_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      prwd_q     <= prwd_d;
      pwdata_q   <= pwdata_d;
      wcnt_q     <= wcnt_d;
      ctrl_q     <= ctrl_d;
      prot_err_q <= prot_err_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        scratch_q[i] <= scratch_d[i];
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave
//   Directed self-checking bench for apb_reg_slave (default parameters:
//   NUM_REGS=4, so scratch registers live at 0x08..0x14).
//   Inputs change 1 time unit after a rising edge; outputs are sampled on
//   the falling edge.
module tb_apb_reg_slave;

  logic        pclock;
  logic        preset;
  logic [31:0] paddr;
  logic        prwd;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        prot_err;

  int checks;
  int errors;

  apb_reg_slave dut (
    .pclock   (pclock),
    .preset   (preset),
    .paddr    (paddr),
    .prwd     (prwd),
    .pwdata   (pwdata),
    .psel     (psel),
    .penable  (penable),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .prot_err (prot_err)
  );

  initial pclock = 1'b0;
  always #5 pclock = ~pclock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_prdata"}, prdata, 32'h0);
    check({tag, "_pready"}, 32'(pready), 32'h0);
    check({tag, "_pslverr"}, 32'(pslverr), 32'h0);
    check({tag, "_prot_err"}, 32'(prot_err), 32'h0);
  endtask

  // Full transfer; returns in the completion cycle leaving psel/penable high,
  // so a following call issues its setup in the cycle after completion.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input int exp_wait, input logic exp_err, input logic [31:0] exp_rdata,
                      input string tag);
    int n;
    @(posedge pclock); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; prwd = wr; pwdata = wdata;
    @(posedge pclock); #1;
    penable = 1'b1;
    n = 0;
    @(negedge pclock);
    while ((pready !== 1'b1) && (n < 40)) begin
      n++;
      @(negedge pclock);
    end
    check({tag, "_pready"}, 32'(pready), 32'h1);
    check({tag, "_waits"}, 32'(n), 32'(exp_wait));
    check({tag, "_pslverr"}, 32'(pslverr), 32'(exp_err));
    check({tag, "_prdata"}, prdata, exp_rdata);
  endtask

  task automatic idle();
    @(posedge pclock); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; prwd = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;

    // 1: reset, then scratch0 write/read with zero wait states
    repeat (2) @(posedge pclock);
    #1 preset = 1'b0;
    @(negedge pclock);
    check_quiet("reset");
    xfer(32'h08, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, "t1_wr");
    idle();
    xfer(32'h08, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, "t1_rd");
    idle();

    // 2: CTRL=3 gives three wait states on the following transfers
    xfer(32'h00, 1'b1, 32'hFFFF_FFF3, 0, 1'b0, 32'h0, "t2_ctrl_wr");
    idle();
    xfer(32'h04, 1'b0, 32'h0, 3, 1'b0, 32'hA5B0_0001, "t2_id_rd");
    idle();
    xfer(32'h00, 1'b0, 32'h0, 3, 1'b0, 32'h0000_0003, "t2_ctrl_rd");
    idle();
    xfer(32'h00, 1'b1, 32'h0, 3, 1'b0, 32'h0, "t2_ctrl_clr");
    idle();

    // 3: error responses, then readback shows nothing changed
    xfer(32'h04, 1'b1, 32'h0, 0, 1'b1, 32'h0, "t3_id_wr");
    idle();
    xfer(32'h02, 1'b0, 32'h0, 0, 1'b1, 32'h0, "t3_unaligned");
    idle();
    xfer(32'h18, 1'b1, 32'h5555_5555, 0, 1'b1, 32'h0, "t3_past_end");
    idle();
    xfer(32'h108, 1'b0, 32'h0, 0, 1'b1, 32'h0, "t3_upper_bit");
    idle();
    xfer(32'h04, 1'b0, 32'h0, 0, 1'b0, 32'hA5B0_0001, "t3_id_rb");
    idle();
    xfer(32'h14, 1'b0, 32'h0, 0, 1'b0, 32'h0, "t3_last_rb");
    idle();
    xfer(32'h14, 1'b1, 32'h1234_5678, 0, 1'b0, 32'h0, "t3_last_wr");
    idle();
    xfer(32'h14, 1'b0, 32'h0, 0, 1'b0, 32'h1234_5678, "t3_last_rd");
    idle();

    // 4a: access phase straight from IDLE
    @(posedge pclock); #1;
    psel = 1'b1; penable = 1'b1; paddr = 32'h08; prwd = 1'b0;
    @(negedge pclock);
    check("t4_noreq_pready", 32'(pready), 32'h0);
    @(posedge pclock); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclock);
    check("t4_prot_pulse", 32'(prot_err), 32'h1);
    check("t4_prot_pready", 32'(pready), 32'h0);
    @(negedge pclock);
    check("t4_prot_one_cycle", 32'(prot_err), 32'h0);

    // 4b: psel dropped during a wait state
    xfer(32'h00, 1'b1, 32'h2, 0, 1'b0, 32'h0, "t4_ctrl2");
    idle();
    @(posedge pclock); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0C; prwd = 1'b1; pwdata = 32'h0000_0BAD;
    @(posedge pclock); #1;
    penable = 1'b1;
    @(negedge pclock);
    check("t4_wait_pready", 32'(pready), 32'h0);
    @(posedge pclock); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclock);
    check("t4_abort_no_early_pulse", 32'(prot_err), 32'h0);
    @(negedge pclock);
    check("t4_abort_pulse", 32'(prot_err), 32'h1);
    xfer(32'h0C, 1'b0, 32'h0, 2, 1'b0, 32'h0, "t4_abort_rb");
    idle();
    xfer(32'h00, 1'b1, 32'h0, 2, 1'b0, 32'h0, "t4_ctrl0");
    idle();

    // 5: back-to-back write then read
    xfer(32'h0C, 1'b1, 32'h0000_0001, 0, 1'b0, 32'h0, "t5_wr");
    xfer(32'h0C, 1'b0, 32'h0, 0, 1'b0, 32'h0000_0001, "t5_rd");
    idle();

    // 6: reset during a write's wait states
    xfer(32'h00, 1'b1, 32'h5, 0, 1'b0, 32'h0, "t6_ctrl5");
    idle();
    @(posedge pclock); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h08; prwd = 1'b1; pwdata = 32'h0000_0077;
    @(posedge pclock); #1;
    penable = 1'b1;
    @(posedge pclock); #1;
    preset = 1'b1;
    @(posedge pclock); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge pclock);
    check_quiet("t6_after_reset");
    xfer(32'h00, 1'b0, 32'h0, 0, 1'b0, 32'h0, "t6_ctrl_rb");
    idle();
    xfer(32'h08, 1'b0, 32'h0, 0, 1'b0, 32'h0, "t6_scratch_rb");
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
